// File: rtl/cpu_core_pkg.sv
// Shared types for the cpu_core slice: opcodes, FSM states and flag bit positions.
package cpu_core_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_XOR  = 4'h8,
    OP_INC  = 4'h9,
    OP_DEC  = 4'hA,
    OP_BRA  = 4'hB,
    OP_BEQ  = 4'hC,
    OP_BMI  = 4'hD,
    OP_BCS  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    FETCH0,
    FETCH1,
    EXEC,
    MEM,
    HALT
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  function automatic logic is_one_word(input opcode_e op);
    return op inside {OP_NOP, OP_INC, OP_DEC, OP_HALT};
  endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// Combinational ALU for cpu_core: computes the result and the next {N,Z,V,C}.
module cpu_core_alu
  import cpu_core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        flags,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags_next
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] wide;
  logic            upd_nz;

  always_comb begin
    wide       = '0;
    upd_nz     = 1'b0;
    result     = a;
    flags_next = flags;
    case (op)
      OP_LDI, OP_LD: begin
        result = b;
        upd_nz = 1'b1;
      end
      OP_ADD: begin
        wide               = {1'b0, a} + {1'b0, b};
        result             = wide[DATA_W-1:0];
        flags_next[FLAG_C] = wide[DATA_W];
        flags_next[FLAG_V] = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
        upd_nz             = 1'b1;
      end
      OP_SUB: begin
        // the ninth bit of the subtraction is the unsigned borrow
        wide               = {1'b0, a} - {1'b0, b};
        result             = wide[DATA_W-1:0];
        flags_next[FLAG_C] = wide[DATA_W];
        flags_next[FLAG_V] = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
        upd_nz             = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR: begin
        if (op == OP_AND)     result = a & b;
        else if (op == OP_OR) result = a | b;
        else                  result = a ^ b;
        flags_next[FLAG_V] = 1'b0;
        upd_nz             = 1'b1;
      end
      OP_INC: begin
        result             = a + DATA_W'(1);
        flags_next[FLAG_V] = !a[MSB] && result[MSB];
        upd_nz             = 1'b1;
      end
      OP_DEC: begin
        result             = a - DATA_W'(1);
        flags_next[FLAG_V] = a[MSB] && !result[MSB];
        upd_nz             = 1'b1;
      end
      default: ;
    endcase
    if (upd_nz) begin
      flags_next[FLAG_N] = result[MSB];
      flags_next[FLAG_Z] = (result == '0);
    end
  end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle parametrised CPU core with req/ready memory port and HALT state.
// Define CPU_CORE_PERF_EN to add the instr_retired counter output.
//
// state  | meaning
// FETCH0 | fetch opcode word at pc
// FETCH1 | fetch operand word at pc
// EXEC   | ALU / LDI / branch / flag update
// MEM    | data access for LD / ST at operand address
// HALT   | stopped until reset
module cpu_core
  import cpu_core_pkg::*;
#(
  parameter int          DATA_W   = 8,
  parameter int          ADDR_W   = 8,
  parameter int          NREGS    = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        nzvc,
`ifdef CPU_CORE_PERF_EN
  output logic [31:0]       instr_retired,
`endif
  output logic              halted
);

  localparam int RW = $clog2(NREGS);

  state_e            state, state_next;
  logic              active;
  opcode_e           op;
  logic [RW-1:0]     rd;
  logic [DATA_W-1:0] word1;
  logic [DATA_W-1:0] regs [NREGS];

  logic              mem_done;
  opcode_e           op_in;
  logic [ADDR_W-1:0] target;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_flags;
  logic              taken;
  logic              wr_exec;
  logic              reg_we;

  assign mem_done = mem_req & mem_ready;
  assign op_in    = opcode_e'(mem_rdata[DATA_W-1 -: 4]);
  assign target   = word1[ADDR_W-1:0];

  // MEM only reaches the ALU for LD, where the loaded word replaces the operand
  always_comb begin
    if (state == MEM)      opnd_b = mem_rdata;
    else if (op == OP_LDI) opnd_b = word1;
    else                   opnd_b = regs[word1[RW-1:0]];
  end

  cpu_core_alu #(.DATA_W(DATA_W)) u_alu (
    .op        (op),
    .a         (regs[rd]),
    .b         (opnd_b),
    .flags     (nzvc),
    .result    (alu_result),
    .flags_next(alu_flags)
  );

  assign taken   = (op == OP_BRA) || (op == OP_BEQ && nzvc[FLAG_Z]) ||
                   (op == OP_BMI && nzvc[FLAG_N]) || (op == OP_BCS && nzvc[FLAG_C]);
  assign wr_exec = op inside {OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_INC, OP_DEC};
  assign reg_we  = (state == EXEC && wr_exec) || (state == MEM && mem_done && op == OP_LD);

  always_comb begin
    state_next = state;
    case (state)
      FETCH0: if (mem_done) state_next = is_one_word(op_in) ? EXEC : FETCH1;
      FETCH1: if (mem_done) state_next = EXEC;
      EXEC: begin
        if (op == OP_HALT)                    state_next = HALT;
        else if (op == OP_LD || op == OP_ST)  state_next = MEM;
        else                                  state_next = FETCH0;
      end
      MEM:    if (mem_done) state_next = FETCH0;
      HALT:   state_next = HALT;
      default: state_next = FETCH0;
    endcase
  end

  // active holds the bus idle until the first clock edge after reset release
  always_comb begin
    mem_req   = active && (state inside {FETCH0, FETCH1, MEM});
    mem_we    = mem_req && (state == MEM) && (op == OP_ST);
    mem_addr  = '0;
    if (mem_req) mem_addr = (state == MEM) ? target : pc;
    mem_wdata = mem_we ? regs[rd] : '0;
    halted    = (state == HALT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FETCH0;
      active <= 1'b0;
      pc     <= ADDR_W'(RESET_PC);
      op     <= OP_NOP;
      rd     <= '0;
      word1  <= '0;
      nzvc   <= '0;
    end else begin
      active <= 1'b1;
      state  <= state_next;
      case (state)
        FETCH0: if (mem_done) begin
          op <= op_in;
          rd <= mem_rdata[RW-1:0];
          pc <= pc + ADDR_W'(1);
        end
        FETCH1: if (mem_done) begin
          word1 <= mem_rdata;
          pc    <= pc + ADDR_W'(1);
        end
        EXEC: begin
          if (taken) pc <= target;
          if (op != OP_LD) nzvc <= alu_flags;
        end
        MEM: if (mem_done && op == OP_LD) nzvc <= alu_flags;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[rd] <= alu_result;
    end
  end

`ifdef CPU_CORE_PERF_EN
  logic retire;
  assign retire = (state == EXEC && state_next != MEM) || (state == MEM && mem_done);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      instr_retired <= '0;
    else if (retire) instr_retired <= instr_retired + 32'd1;
  end
`endif

endmodule

// File: tb/tb_cpu_core.sv
// Directed self-checking bench for cpu_core with a wait-state memory model.
module tb_cpu_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mem_req, mem_we, mem_ready, halted;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [3:0] nzvc;
`ifdef CPU_CORE_PERF_EN
  logic [31:0] instr_retired;
`endif

  always #5 clk = ~clk;

  cpu_core dut (
    .clk      (clk),
    .reset    (reset),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .pc       (pc),
    .nzvc     (nzvc),
`ifdef CPU_CORE_PERF_EN
    .instr_retired(instr_retired),
`endif
    .halted   (halted)
  );

  logic [7:0] img      [256];
  logic [7:0] wr_data  [256];
  logic       wr_valid [256];
  int waits = 0;
  int wait_cnt = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int t_prev = 0;
  int we_cyc = 0;
  int req_cnt = 0;
  int stab_err = 0;
  logic       pend = 1'b0;
  logic       p_we;
  logic [7:0] p_addr, p_wdata;

  // memory: rom image overlaid with words written by the core
  assign mem_ready = (wait_cnt >= waits);
  assign mem_rdata = wr_valid[mem_addr] ? wr_data[mem_addr] : img[mem_addr];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 0;
      for (int i = 0; i < 256; i++) wr_valid[i] <= 1'b0;
    end else if (mem_req) begin
      if (mem_ready) begin
        wait_cnt <= 0;
        if (mem_we) begin
          wr_data[mem_addr]  <= mem_wdata;
          wr_valid[mem_addr] <= 1'b1;
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_we) we_cyc++;
    if (mem_req) req_cnt++;
    if (reset && pend && (!mem_req || mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wdata))
      stab_err++;
    pend    = reset && mem_req && !mem_ready;
    p_addr  = mem_addr;
    p_we    = mem_we;
    p_wdata = mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_fetch(input logic [7:0] a, output int at);
    int n = 0;
    while (!(mem_req && !mem_we && mem_addr == a) && n < 60) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    if (n >= 60) chk($sformatf("fetch_timeout_%02h", a), n, 0);
  endtask

  task automatic step(input logic [7:0] a, input int lat, input logic [3:0] fl);
    int t;
    wait_fetch(a, t);
    chk($sformatf("lat_%02h", a), t - t_prev, lat);
    chk($sformatf("nzvc_%02h", a), nzvc, fl);
    chk($sformatf("pc_%02h", a), pc, a);
    t_prev = t;
  endtask

  task automatic put2(input logic [7:0] a, input logic [7:0] w0, input logic [7:0] w1);
    img[a]      = w0;
    img[a + 1'b1] = w1;
  endtask

  initial begin
    int t, n, r0;
    for (int i = 0; i < 256; i++) img[i] = 8'hF0;
    put2(8'h00, 8'h11, 8'h7F);  // LDI R1,#7F
    put2(8'h02, 8'h12, 8'h01);  // LDI R2,#01
    put2(8'h04, 8'h41, 8'h02);  // ADD R1,R2
    put2(8'h06, 8'h31, 8'h40);  // ST R1,[40]
    put2(8'h08, 8'h23, 8'h40);  // LD R3,[40]
    put2(8'h0A, 8'h33, 8'h41);  // ST R3,[41]
    put2(8'h0C, 8'h51, 8'h01);  // SUB R1,R1
    put2(8'h0E, 8'hC0, 8'h20);  // BEQ 20
    put2(8'h20, 8'hE0, 8'h30);  // BCS 30 (not taken)
    img[8'h22] = 8'h94;         // INC R4
    img[8'h23] = 8'hA5;         // DEC R5
    put2(8'h24, 8'h45, 8'h04);  // ADD R5,R4
    put2(8'h26, 8'h35, 8'h42);  // ST R5,[42]
    put2(8'h28, 8'hE0, 8'h2C);  // BCS 2C (taken)
    put2(8'h2C, 8'h72, 8'h03);  // OR R2,R3
    put2(8'h2E, 8'h82, 8'h02);  // XOR R2,R2
    put2(8'h30, 8'h54, 8'h03);  // SUB R4,R3
    put2(8'h32, 8'hD0, 8'hF0);  // BMI F0
    put2(8'hF0, 8'hB0, 8'hFF);  // BRA FF
    img[8'hFF] = 8'h00;         // NOP, wraps to 00

    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 8'h00);
    chk("rst_nzvc", nzvc, 4'h0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_wdata", mem_wdata, 8'h00);
    chk("rst_halted", halted, 1'b0);

    reset = 1'b1;
    t_prev = cyc;
    wait_fetch(8'h00, t);
    chk("first_fetch", t - t_prev, 1);
    t_prev = t;

    step(8'h02, 3, 4'b0000);
    step(8'h04, 3, 4'b0000);
    step(8'h06, 3, 4'b1010);
    step(8'h08, 4, 4'b1010);
    step(8'h0A, 4, 4'b1010);
    step(8'h0C, 4, 4'b1010);
    step(8'h0E, 3, 4'b0100);
    step(8'h20, 3, 4'b0100);
    step(8'h22, 3, 4'b0100);
    step(8'h23, 2, 4'b0000);
    step(8'h24, 2, 4'b1000);
    step(8'h26, 3, 4'b0101);
    step(8'h28, 4, 4'b0101);
    step(8'h2C, 3, 4'b0101);
    step(8'h2E, 3, 4'b1001);
    step(8'h30, 3, 4'b0101);
    step(8'h32, 3, 4'b1011);
    step(8'hF0, 3, 4'b1011);
    step(8'hFF, 3, 4'b1011);
    step(8'h00, 2, 4'b1011);

    chk("mem40", wr_data[8'h40], 8'h80);
    chk("mem41", wr_data[8'h41], 8'h80);
    chk("mem42", wr_data[8'h42], 8'h00);
    chk("we_cycles", we_cyc, 3);
`ifdef CPU_CORE_PERF_EN
    chk("retired_p1", instr_retired, 20);
`endif

    #2 reset = 1'b0;
    #1;
    chk("rst2_req", mem_req, 1'b0);
    chk("rst2_pc", pc, 8'h00);
    chk("rst2_nzvc", nzvc, 4'h0);

    repeat (2) @(negedge clk);
    put2(8'h00, 8'h11, 8'h7F);  // LDI R1,#7F
    put2(8'h02, 8'h27, 8'h40);  // LD R7,[40]
    waits = 2;
    reset = 1'b1;
    wait_fetch(8'h00, t);
    t_prev = t;
    step(8'h02, 7, 4'b0000);
    n = 0;
    while (!(mem_req && mem_addr == 8'h40) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("ld_mem_reached", n < 60, 1'b1);
    chk("ld_stalled", mem_ready, 1'b0);
    chk("stable_waits", stab_err, 0);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_req", mem_req, 1'b0);
    chk("rst_mid_addr", mem_addr, 8'h00);
    chk("rst_mid_pc", pc, 8'h00);

    repeat (2) @(negedge clk);
    put2(8'h00, 8'h31, 8'h50);  // ST R1,[50]
    img[8'h02] = 8'hF0;         // HALT
    waits = 0;
    reset = 1'b1;
    wait_fetch(8'h00, t);
    t_prev = t;
    chk("p3_first_addr", mem_addr, 8'h00);
    step(8'h02, 4, 4'b0000);
    n = 0;
    while (!halted && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("halted", halted, 1'b1);
    chk("halt_lat", cyc - t_prev, 2);
    r0 = req_cnt;
    repeat (20) @(negedge clk);
    chk("halt_no_req", req_cnt - r0, 0);
    chk("halt_pc", pc, 8'h03);
    chk("mem50_reg_reset", wr_data[8'h50], 8'h00);
`ifdef CPU_CORE_PERF_EN
    chk("retired_p3", instr_retired, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
# cpu_core

Parametrised multi-cycle processor core, the next generation of the 8-bit microcontroller CPU. It generalises data width, address width and register count, and replaces the fixed single-cycle memory port with a req/ready handshake that tolerates any number of wait states. It sits between the system memory/bus fabric and the top level, and adds a HALT state and a debug/status view.

## Interface
- DATA_W, 8: data and instruction word width; must satisfy DATA_W ≥ 4 + log2(NREGS)
- ADDR_W, 8: address width; must satisfy ADDR_W ≤ DATA_W
- NREGS, 16: general registers; power of two, ≥ 2
- RESET_PC, 0: fetch address after reset
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; reset=0 resets everything
- mem_req  out  1  memory access request
- mem_we  out  1  write qualifier, valid only with mem_req
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  read data, sampled when mem_req & mem_ready
- mem_ready  in  1  access completes in any cycle where mem_req & mem_ready
- pc  out  ADDR_W  current program counter
- nzvc  out  4  flags {N,Z,V,C}
- halted  out  1  core in HALT
- instr_retired  out  32  present only with CPU_CORE_PERF_EN

## Operation
- Word0 = {opcode[DATA_W-1 -: 4], rd[RW-1:0]}, RW=log2(NREGS); other bits ignored. Word1 carries rs[RW-1:0], an immediate, or an address[ADDR_W-1:0].
- Opcodes: 0 NOP; 1 LDI rd,#imm; 2 LD rd,[a]; 3 ST rd,[a]; 4 ADD; 5 SUB; 6 AND; 7 OR; 8 XOR (rd ← rd op rs); 9 INC rd; A DEC rd; B BRA a; C BEQ (Z); D BMI (N); E BCS (C); F HALT.
- One-word opcodes: 0, 9, A, F. All others are two-word.
- States: FETCH0 → (one-word ? EXEC : FETCH1) → EXEC → (LD/ST ? MEM : FETCH0) → FETCH0. HALT is entered from EXEC on F and is left only by reset.
- FETCH0/FETCH1: mem_req=1, mem_we=0, mem_addr=pc. On completion, capture the word and increment pc modulo 2^ADDR_W.
- EXEC: ALU, LDI and flag updates; a taken branch loads pc ← a; INC/DEC write rd.
- MEM: mem_addr=a. ST drives mem_we=1 and mem_wdata=reg[rd]. LD writes rd on completion.
- Flags:
  - ADD: C = carry out; V = signed overflow.
  - SUB: rd−rs; C = borrow (rd<rs unsigned); V = signed overflow.
  - AND/OR/XOR: V=0, C unchanged.
  - INC/DEC: N,Z,V updated, C unchanged.
  - LDI/LD: N,Z updated, V,C unchanged.
  - N = result MSB; Z = result==0.
  - ST, branches, NOP and HALT leave flags unchanged.
- rs == rd is legal.
- mem_ready is ignored while mem_req=0.

## Timing
- Reset values: pc=RESET_PC, registers=0, nzvc=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, state=FETCH0.
- Reset assertion clears all outputs immediately, with no clock edge needed, including mid-access.
- The first fetch request appears in the first cycle after reset deasserts.
- Zero-wait latency: NOP/INC/DEC = 2 cycles; LDI/ALU/branch = 3; LD/ST = 4; HALT = 2, after which halted=1.
- Each cycle of mem_ready=0 during a request adds one cycle.
- mem_addr, mem_we and mem_wdata stay stable while mem_req=1 until completion. mem_req never drops before completion.
- Register and flag writes take effect at the end of EXEC/MEM and are visible to the next instruction.
- In HALT, mem_req=0 permanently.

## Configuration
- CPU_CORE_PERF_EN defined:
  - Adds output instr_retired, reset to 0.
  - Increments by 1 in the last cycle of every instruction, including HALT, and wraps at 2^32.
- Undefined: the port and counter are absent. Core behaviour is otherwise identical.

## Structure
- Package cpu_core_pkg holds:
  - the opcode enumeration;
  - the state enumeration (FETCH0, FETCH1, EXEC, MEM, HALT);
  - the flag bit indices N=3, V=1, C=0, Z=2.
- Sub-module cpu_core_alu is purely combinational: operands, opcode → result, nzvc_next.
- Register file and FSM are inline in cpu_core.

## Test plan
- Arithmetic flags: LDI R1,#7F (11 7F); LDI R2,#01 (12 01); ADD R1,R2 (41 02) → R1=80, nzvc=1010. Each instruction takes 3 cycles with a zero-wait memory.
- Wait states: memory holds mem_ready low 2 cycles per access → LDI takes 7 cycles; mem_addr/mem_req stable throughout each wait.
- Store/load round-trip: with R1=80, ST R1,[40] (31 40) → mem_we=1 only in the MEM cycle, memory[40]=80. Then LD R3,[40] (23 40) → R3=80, N=1, Z=0.
- Branches: SUB R1,R1 → Z=1, C=0. BEQ 20 → pc=20. BCS 30 → not taken, pc advances by 2.
- Halt and wrap: NOP at FF → next fetch at 00. HALT → halted=1 and no further mem_req. With PERF_EN, instr_retired equals the number of executed instructions.
- Reset during a stalled LD MEM cycle → mem_req=0 immediately. After release, first fetch at RESET_PC with registers and flags zero.
